keypad_input_stage: RTL and testbench

//  Front end between board pins (KEY[3:0], SW[9:0]) and main_control/datapath.

---
 rtl/keypad_input_stage_pkg.sv | 22 ++
 rtl/keypad_input_stage_debounce.sv | 68 ++++++
 rtl/keypad_input_stage.sv | 151 +++++++++++++++
 tb/tb_keypad_input_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_input_stage_pkg.sv
// Shared definitions for the keypad input stage: FSM encoding and key indices.
package keypad_input_stage_pkg;

  // Request-builder FSM. Code 2'b11 is never entered on purpose and falls back to idle.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_GOT_AMOUNT = 2'b01,
    ST_READY      = 2'b10,
    ST_UNUSED     = 2'b11
  } state_e;

  // Board push-button lanes
  localparam int NUM_KEYS   = 4;
  localparam int KEY_START  = 0;
  localparam int KEY_LOAD   = 1;
  localparam int KEY_SPARE  = 2;
  localparam int KEY_CANCEL = 3;

  // Slide-switch bank width
  localparam int SW_W = 10;

endpackage

// File: rtl/keypad_input_stage_debounce.sv
// Per-key synchroniser, debounce counter and press-edge detector.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic             sample;

  assign sample = sync2_q;
  assign level  = level_q;
  assign press  = press_q;

  // The counter measures how long the sample has disagreed with the accepted level;
  // any return to agreement restarts it, so bounces shorter than the window vanish.
  // The synchroniser resets to "pressed" and presses are only reported once a
  // released level has been observed, so a key held through reset stays silent.
  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    armed_d = armed_q | (level_q & sample);
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sample;
      press_d = level_q & ~sample & armed_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/keypad_input_stage.sv
// Board-pin front end: debounced key pulses, switch capture and a held
// amount/player_key request toward main_control with valid/ack handshake.
module keypad_input_stage
  import keypad_input_stage_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int DATA_W          = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [3:0]        key_n,
  input  logic [SW_W-1:0]   sw,
  input  logic              busy,
  input  logic              ack,
  output logic              start_pulse,
  output logic              load_pulse,
  output logic [DATA_W-1:0] amount,
  output logic [DATA_W-1:0] player_key,
  output logic              req_valid,
  output logic              input_error
);

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  // One debouncer per push-button
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw_n (key_n[g]),
      .level (key_level[g]),
      .press (key_press[g])
    );
  end

  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic [DATA_W-1:0] sw_data;

  assign sw_data = sw_s2_q[DATA_W-1:0];

  // Two-flop synchroniser on the switch bank; the FSM only sees the second stage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] amount_q, amount_d;
  logic [DATA_W-1:0] player_key_q, player_key_d;
  logic              req_valid_q, req_valid_d;
  logic              start_pulse_q, start_pulse_d;
  logic              load_pulse_q, load_pulse_d;
  logic              input_error_q, input_error_d;
  logic              load_ok;

  // A load press is only honoured when main_control is idle; otherwise it is dropped
  assign load_ok = key_press[KEY_LOAD] & ~busy;

  // Next-state and output decode; cancel overrides everything except start
  always_comb begin
    state_d       = state_q;
    amount_d      = amount_q;
    player_key_d  = player_key_q;
    req_valid_d   = req_valid_q;
    start_pulse_d = key_press[KEY_START];
    load_pulse_d  = 1'b0;
    input_error_d = 1'b0;
    if (key_press[KEY_CANCEL]) begin
      state_d     = ST_IDLE;
      req_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_valid_d = 1'b0;
          if (load_ok) begin
            if (sw_data == '0) begin
              input_error_d = 1'b1;
            end else begin
              amount_d     = sw_data;
              load_pulse_d = 1'b1;
              state_d      = ST_GOT_AMOUNT;
            end
          end
        end
        ST_GOT_AMOUNT: begin
          req_valid_d = 1'b0;
          if (load_ok) begin
            player_key_d = sw_data;
            load_pulse_d = 1'b1;
            req_valid_d  = 1'b1;
            state_d      = ST_READY;
          end
        end
        ST_READY: begin
          req_valid_d = 1'b1;
          if (ack) begin
            req_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      amount_q      <= '0;
      player_key_q  <= '0;
      req_valid_q   <= 1'b0;
      start_pulse_q <= 1'b0;
      load_pulse_q  <= 1'b0;
      input_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      amount_q      <= amount_d;
      player_key_q  <= player_key_d;
      req_valid_q   <= req_valid_d;
      start_pulse_q <= start_pulse_d;
      load_pulse_q  <= load_pulse_d;
      input_error_q <= input_error_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign load_pulse  = load_pulse_q;
  assign amount      = amount_q;
  assign player_key  = player_key_q;
  assign req_valid   = req_valid_q;
  assign input_error = input_error_q;

  // Spare key, debounced levels and upper switches have no consumer here
  logic unused_bits;
  assign unused_bits = ^{key_level, key_press[KEY_SPARE], sw_s2_q[SW_W-1:DATA_W]};

endmodule

// File: tb/tb_keypad_input_stage.sv
// Directed bench for keypad_input_stage with a 4-cycle debounce window.
module tb_keypad_input_stage;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic       busy, ack;
  logic       start_pulse, load_pulse, req_valid, input_error;
  logic [7:0] amount, player_key;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int n_start = 0, n_load = 0, n_err = 0, last_start_cyc = -1;

  keypad_input_stage #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .DATA_W(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_n      (key_n),
    .sw         (sw),
    .busy       (busy),
    .ack        (ack),
    .start_pulse(start_pulse),
    .load_pulse (load_pulse),
    .amount     (amount),
    .player_key (player_key),
    .req_valid  (req_valid),
    .input_error(input_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse tallies sampled on the falling edge
  always @(negedge clock) begin
    if (start_pulse) begin n_start++; last_start_cyc = cyc; end
    if (load_pulse)  n_load++;
    if (input_error) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_mask(input logic [3:0] mask, input int low_n, input int high_n);
    key_n = ~mask;
    tick(low_n);
    key_n = 4'hF;
    tick(high_n);
  endtask

  task automatic test_reset;
    resetn = 1'b1; key_n = 4'hF; sw = '0; busy = 1'b0; ack = 1'b0;
    #3 resetn = 1'b0;
    tick(2);
    nvec++; if (start_pulse !== 1'b0) begin nfail++; $display("FAIL reset_start got %b want 0", start_pulse); end
    nvec++; if (load_pulse  !== 1'b0) begin nfail++; $display("FAIL reset_load got %b want 0", load_pulse); end
    nvec++; if (amount      !== 8'h00) begin nfail++; $display("FAIL reset_amount got %h want 00", amount); end
    nvec++; if (player_key  !== 8'h00) begin nfail++; $display("FAIL reset_key got %h want 00", player_key); end
    nvec++; if (req_valid   !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", req_valid); end
    nvec++; if (input_error !== 1'b0) begin nfail++; $display("FAIL reset_err got %b want 0", input_error); end
    resetn = 1'b1;
    tick(6);
  endtask

  task automatic test_start;
    int b, c0;
    b = n_start;
    press_mask(4'b0001, 3, 8);
    nvec++; if (n_start !== b) begin nfail++; $display("FAIL short_press pulses %0d want 0", n_start - b); end
    b = n_start;
    c0 = cyc;
    press_mask(4'b0001, 10, 8);
    nvec++; if (n_start - b !== 1) begin nfail++; $display("FAIL start_count got %0d want 1", n_start - b); end
    nvec++; if (last_start_cyc - c0 !== 7) begin nfail++; $display("FAIL start_latency got %0d want 7", last_start_cyc - c0); end
    nvec++; if (n_load !== 0) begin nfail++; $display("FAIL start_no_load got %0d want 0", n_load); end
  endtask

  task automatic test_bounce;
    int b;
    sw = 10'h011;
    tick(3);
    b = n_load;
    for (int i = 0; i < 6; i++) begin
      key_n[1] = (i % 2 == 1);
      tick(2);
    end
    key_n[1] = 1'b0;
    tick(10);
    key_n[1] = 1'b1;
    tick(8);
    nvec++; if (n_load - b !== 1) begin nfail++; $display("FAIL bounce_count got %0d want 1", n_load - b); end
    nvec++; if (amount !== 8'h11) begin nfail++; $display("FAIL bounce_amount got %h want 11", amount); end
    nvec++; if (n_err !== 0) begin nfail++; $display("FAIL bounce_err got %0d want 0", n_err); end
  endtask

  // Cancel from GOT_AMOUNT returns to IDLE: next load fills amount again
  task automatic test_cancel_got;
    int b;
    b = n_load;
    press_mask(4'b1000, 10, 8);
    nvec++; if (n_load !== b) begin nfail++; $display("FAIL cancel_got_load got %0d want 0", n_load - b); end
    sw = 10'h033;
    press_mask(4'b0010, 10, 8);
    nvec++; if (amount !== 8'h33) begin nfail++; $display("FAIL cancel_got_amount got %h want 33", amount); end
    nvec++; if (req_valid !== 1'b0) begin nfail++; $display("FAIL cancel_got_valid got %b want 0", req_valid); end
    press_mask(4'b1000, 10, 8);
  endtask

  task automatic test_capture;
    int b;
    b = n_load;
    sw = 10'h02A;
    press_mask(4'b0010, 10, 8);
    ack = 1'b1; tick(3); ack = 1'b0;
    sw = 10'h35C;
    press_mask(4'b0010, 10, 8);
    nvec++; if (amount !== 8'h2A) begin nfail++; $display("FAIL cap_amount got %h want 2a", amount); end
    nvec++; if (player_key !== 8'h5C) begin nfail++; $display("FAIL cap_key got %h want 5c", player_key); end
    nvec++; if (req_valid !== 1'b1) begin nfail++; $display("FAIL cap_valid got %b want 1", req_valid); end
    nvec++; if (n_load - b !== 2) begin nfail++; $display("FAIL cap_loads got %0d want 2", n_load - b); end
    sw = 10'h077;
    press_mask(4'b0010, 10, 8);
    nvec++; if (n_load - b !== 2) begin nfail++; $display("FAIL ready_ignore got %0d want 2", n_load - b); end
    sw = 10'h099;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      nvec++; if (amount !== 8'h2A) begin nfail++; $display("FAIL hold_amount cyc %0d got %h want 2a", i, amount); end
      nvec++; if (player_key !== 8'h5C) begin nfail++; $display("FAIL hold_key cyc %0d got %h want 5c", i, player_key); end
      nvec++; if (req_valid !== 1'b1) begin nfail++; $display("FAIL hold_valid cyc %0d got %b want 1", i, req_valid); end
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    nvec++; if (req_valid !== 1'b0) begin nfail++; $display("FAIL ack_valid got %b want 0", req_valid); end
    nvec++; if (amount !== 8'h2A) begin nfail++; $display("FAIL ack_amount got %h want 2a", amount); end
    nvec++; if (player_key !== 8'h5C) begin nfail++; $display("FAIL ack_key got %h want 5c", player_key); end
  endtask

  task automatic test_zero;
    int bl, be;
    bl = n_load; be = n_err;
    sw = 10'h000;
    press_mask(4'b0010, 10, 8);
    nvec++; if (n_err - be !== 1) begin nfail++; $display("FAIL zero_err got %0d want 1", n_err - be); end
    nvec++; if (n_load !== bl) begin nfail++; $display("FAIL zero_load got %0d want 0", n_load - bl); end
    sw = 10'h044;
    press_mask(4'b0010, 10, 8);
    nvec++; if (amount !== 8'h44) begin nfail++; $display("FAIL zero_idle_amount got %h want 44", amount); end
  endtask

  task automatic test_busy;
    int b;
    b = n_load;
    busy = 1'b1;
    sw = 10'h066;
    press_mask(4'b0010, 10, 8);
    busy = 1'b0;
    nvec++; if (n_load !== b) begin nfail++; $display("FAIL busy_load got %0d want 0", n_load - b); end
    nvec++; if (player_key !== 8'h5C) begin nfail++; $display("FAIL busy_key got %h want 5c", player_key); end
    sw = 10'h067;
    press_mask(4'b0010, 10, 8);
    nvec++; if (n_load - b !== 1) begin nfail++; $display("FAIL busy_after got %0d want 1", n_load - b); end
    nvec++; if (player_key !== 8'h67) begin nfail++; $display("FAIL busy_after_key got %h want 67", player_key); end
    nvec++; if (req_valid !== 1'b1) begin nfail++; $display("FAIL busy_after_valid got %b want 1", req_valid); end
  endtask

  task automatic test_cancel_priority;
    int b;
    b = n_load;
    sw = 10'h012;
    key_n = 4'b0111;
    tick(6);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(3);
    key_n = 4'hF;
    tick(8);
    nvec++; if (req_valid !== 1'b0) begin nfail++; $display("FAIL cxl_ack_valid got %b want 0", req_valid); end
    nvec++; if (amount !== 8'h44) begin nfail++; $display("FAIL cxl_ack_amount got %h want 44", amount); end
    sw = 10'h021;
    press_mask(4'b0010, 10, 8);
    nvec++; if (amount !== 8'h21) begin nfail++; $display("FAIL cxl_idle_amount got %h want 21", amount); end
    b = n_load;
    sw = 10'h022;
    press_mask(4'b1010, 10, 8);
    nvec++; if (n_load !== b) begin nfail++; $display("FAIL cxl_load got %0d want 0", n_load - b); end
    nvec++; if (player_key !== 8'h67) begin nfail++; $display("FAIL cxl_load_key got %h want 67", player_key); end
    sw = 10'h023;
    press_mask(4'b0010, 10, 8);
    nvec++; if (amount !== 8'h23) begin nfail++; $display("FAIL cxl_load_idle got %h want 23", amount); end
  endtask

  task automatic test_reset_mid;
    int b;
    key_n[1] = 1'b0;
    tick(4);
    #2 resetn = 1'b0;
    #1;
    nvec++; if (amount !== 8'h00) begin nfail++; $display("FAIL mid_amount got %h want 00", amount); end
    nvec++; if (player_key !== 8'h00) begin nfail++; $display("FAIL mid_key got %h want 00", player_key); end
    nvec++; if (req_valid !== 1'b0) begin nfail++; $display("FAIL mid_valid got %b want 0", req_valid); end
    nvec++; if (load_pulse !== 1'b0) begin nfail++; $display("FAIL mid_load got %b want 0", load_pulse); end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    b = n_load;
    tick(15);
    nvec++; if (n_load !== b) begin nfail++; $display("FAIL held_key got %0d want 0", n_load - b); end
    key_n = 4'hF;
    tick(10);
    sw = 10'h05A;
    press_mask(4'b0010, 10, 8);
    nvec++; if (n_load - b !== 1) begin nfail++; $display("FAIL repress got %0d want 1", n_load - b); end
    nvec++; if (amount !== 8'h5A) begin nfail++; $display("FAIL repress_amount got %h want 5a", amount); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_bounce;
    test_cancel_got;
    test_capture;
    test_zero;
    test_busy;
    test_cancel_priority;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
